// File: rtl/cgia_pkg.sv
// Shared definitions for the CGIA display pixel path: mode encodings,
// sequencer state type and pixels-per-word helpers.
package cgia_pkg;

  localparam int WORD_W = 16;
  localparam int CNT_W  = 4;

  localparam logic [1:0] MODE_1BPP = 2'b00;
  localparam logic [1:0] MODE_2BPP = 2'b01;
  localparam logic [1:0] MODE_4BPP = 2'b10;
  localparam logic [1:0] MODE_8BPP = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STARVE = 2'd2
  } seq_state_t;

  // Pixels carried by one 16-bit display word at the given depth.
  function automatic logic [4:0] ppw(input logic [1:0] mode);
    logic [4:0] n;
    case (mode)
      MODE_1BPP: n = 5'd16;
      MODE_2BPP: n = 5'd8;
      MODE_4BPP: n = 5'd4;
      default:   n = 5'd2;
    endcase
    return n;
  endfunction

  // Shift cycles that follow a load: PPW-1, always fits the counter.
  function automatic logic [CNT_W-1:0] shift_count(input logic [1:0] mode);
    logic [4:0] n;
    n = ppw(mode) - 5'd1;
    return n[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/word_fifo.sv
// Small synchronous word FIFO between the fetch unit and the sequencer.
// The head is read combinationally so a load can latch it on the same edge
// that pops it; a pushed word is never visible at the head before the next
// edge. Flush clears everything and discards a same-cycle push.
module word_fifo
  import cgia_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] wdat,
  output logic [WORD_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking; flush overrides push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because occupancy gates the reads.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdat;
  end

endmodule

// File: rtl/pixel_sequencer.sv
// Feeds the CGIA shift register: buffers display words and issues one load
// followed by PPW-1 shift strobes per word at the depth latched at the load.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | blanking / disabled, strobes quiet
//   RUN    | a word is in the shift register, cnt shifts still to go
//   STARVE | display active but no word was available; load on arrival
module pixel_sequencer
  import cgia_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic              dotclk_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic              flush_i,
  input  logic [1:0]        mode_i,
  input  logic [WORD_W-1:0] wdat_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  output logic [WORD_W-1:0] dat_o,
  output logic              load_o,
  output logic              shift1_o,
  output logic              shift2_o,
  output logic              shift4_o,
  output logic              shift8_o,
  output logic              underrun_o
);

  seq_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        mode_q, mode_d;
  logic [WORD_W-1:0] dat_d;
  logic              load_d, sh1_d, sh2_d, sh4_d, sh8_d, und_d;
  logic              start_load;

  logic              fifo_full;
  logic              fifo_empty;
  logic [WORD_W-1:0] fifo_head;
  logic              fifo_push;

  assign wready_o  = ~fifo_full & ~reset_i;
  assign fifo_push = wvalid_i & wready_o;

  word_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk   (dotclk_i),
    .rst   (reset_i),
    .flush (flush_i),
    .push  (fifo_push),
    .pop   (load_d),
    .wdat  (wdat_i),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next state, counter and next-cycle strobe values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    dat_d      = dat_o;
    load_d     = 1'b0;
    sh1_d      = 1'b0;
    sh2_d      = 1'b0;
    sh4_d      = 1'b0;
    sh8_d      = 1'b0;
    und_d      = 1'b0;
    start_load = 1'b0;

    if (!enable_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) start_load = 1'b1;
          else             state_d    = STARVE;
        end
        RUN: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            case (mode_q)
              MODE_1BPP: sh1_d = 1'b1;
              MODE_2BPP: sh2_d = 1'b1;
              MODE_4BPP: sh4_d = 1'b1;
              default:   sh8_d = 1'b1;
            endcase
          end else if (!fifo_empty) begin
            start_load = 1'b1;
          end else begin
            und_d   = 1'b1;
            state_d = STARVE;
          end
        end
        STARVE: begin
          if (!fifo_empty) start_load = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    // A load takes the head word and re-samples the pixel depth.
    if (start_load) begin
      load_d  = 1'b1;
      dat_d   = fifo_head;
      mode_d  = mode_i;
      cnt_d   = shift_count(mode_i);
      state_d = RUN;
    end
  end

  // State, counter and registered outputs; reset aborts any word in flight.
  always_ff @(posedge dotclk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mode_q     <= MODE_1BPP;
      dat_o      <= '0;
      load_o     <= 1'b0;
      shift1_o   <= 1'b0;
      shift2_o   <= 1'b0;
      shift4_o   <= 1'b0;
      shift8_o   <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      dat_o      <= dat_d;
      load_o     <= load_d;
      shift1_o   <= sh1_d;
      shift2_o   <= sh2_d;
      shift4_o   <= sh4_d;
      shift8_o   <= sh8_d;
      underrun_o <= und_d;
    end
  end

endmodule

// File: tb/tb_pixel_sequencer.sv
// Directed bench for pixel_sequencer: the expected strobe/data pattern of each
// cycle is queued when stimulus is set up and popped as the DUT advances.
module tb_pixel_sequencer;
  import cgia_pkg::*;

  logic        dotclk_i;
  logic        reset_i;
  logic        enable_i;
  logic        flush_i;
  logic [1:0]  mode_i;
  logic [15:0] wdat_i;
  logic        wvalid_i;
  logic        wready_o;
  logic [15:0] dat_o;
  logic        load_o, shift1_o, shift2_o, shift4_o, shift8_o, underrun_o;

  pixel_sequencer #(.BUF_DEPTH(2)) dut (
    .dotclk_i   (dotclk_i),
    .reset_i    (reset_i),
    .enable_i   (enable_i),
    .flush_i    (flush_i),
    .mode_i     (mode_i),
    .wdat_i     (wdat_i),
    .wvalid_i   (wvalid_i),
    .wready_o   (wready_o),
    .dat_o      (dat_o),
    .load_o     (load_o),
    .shift1_o   (shift1_o),
    .shift2_o   (shift2_o),
    .shift4_o   (shift4_o),
    .shift8_o   (shift8_o),
    .underrun_o (underrun_o)
  );

  initial dotclk_i = 1'b0;
  always #5 dotclk_i = ~dotclk_i;

  typedef struct {
    logic [5:0]  strb;   // {load, shift1, shift2, shift4, shift8, underrun}
    logic [15:0] dat;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] feed[$];
  logic [15:0] m_dat;
  int          n_assert;
  int          n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic exp_push(input logic [5:0] s, input string tag);
    exp_t e;
    e.strb = s;
    e.dat  = m_dat;
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  task automatic exp_load(input logic [15:0] w);
    m_dat = w;
    exp_push(6'b100000, "load");
  endtask

  task automatic exp_shift(input logic [1:0] mode, input int n);
    logic [5:0] s;
    case (mode)
      MODE_1BPP: s = 6'b010000;
      MODE_2BPP: s = 6'b001000;
      MODE_4BPP: s = 6'b000100;
      default:   s = 6'b000010;
    endcase
    for (int i = 0; i < n; i++) exp_push(s, "shift");
  endtask

  task automatic exp_und();
    exp_push(6'b000001, "underrun");
  endtask

  task automatic exp_zero(input int n);
    for (int i = 0; i < n; i++) exp_push(6'b000000, "quiet");
  endtask

  task automatic set_feed();
    wvalid_i = (feed.size() > 0);
    wdat_i   = (feed.size() > 0) ? feed[0] : 16'h0000;
  endtask

  // One dot clock: sample the handshake, advance, check this cycle's outputs.
  task automatic step();
    logic acc;
    exp_t e;
    logic [5:0] obs;
    acc = wvalid_i && wready_o;
    @(posedge dotclk_i);
    #1;
    obs = {load_o, shift1_o, shift2_o, shift4_o, shift8_o, underrun_o};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({e.tag, " strobes"}, 32'(obs), 32'(e.strb));
      chk({e.tag, " dat_o"}, 32'(dat_o), 32'(e.dat));
    end
    chk("strobe exclusivity", 32'($countones(obs[5:1]) <= 1), 32'd1);
    if (acc && feed.size() > 0) void'(feed.pop_front());
    set_feed();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " strobes"}, 32'({load_o, shift1_o, shift2_o, shift4_o, shift8_o, underrun_o}), 32'd0);
    chk({tag, " dat_o"}, 32'(dat_o), 32'd0);
    chk({tag, " wready_o"}, 32'(wready_o), 32'd0);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    m_dat    = 16'h0000;
    reset_i  = 1'b1;
    enable_i = 1'b0;
    flush_i  = 1'b0;
    mode_i   = MODE_1BPP;
    wdat_i   = 16'h0000;
    wvalid_i = 1'b0;

    // Reset state
    #3;
    chk_reset_outputs("reset");
    @(posedge dotclk_i);
    #1;
    reset_i = 1'b0;
    #1;
    chk("wready after reset", 32'(wready_o), 32'd1);

    // 1bpp: two words, 16 pixels each, then underrun
    mode_i = MODE_1BPP;
    feed.push_back(16'h1234);
    feed.push_back(16'hABCD);
    set_feed();
    step();
    chk("1bpp wready one queued", 32'(wready_o), 32'd1);
    step();
    chk("1bpp wready two queued", 32'(wready_o), 32'd0);
    enable_i = 1'b1;
    exp_load(16'h1234);
    exp_shift(MODE_1BPP, 15);
    exp_load(16'hABCD);
    exp_shift(MODE_1BPP, 15);
    exp_und();
    steps(33);
    enable_i = 1'b0;
    exp_zero(1);
    step();

    // 8bpp with the fetch side keeping the FIFO topped up
    mode_i = MODE_8BPP;
    for (int i = 0; i < 8; i++) feed.push_back(16'hA000 + 16'(i));
    set_feed();
    step();
    chk("8bpp wready one queued", 32'(wready_o), 32'd1);
    step();
    chk("8bpp wready two queued", 32'(wready_o), 32'd0);
    enable_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_load(16'hA000 + 16'(i));
      exp_shift(MODE_8BPP, 1);
    end
    steps(12);
    feed.delete();
    set_feed();
    enable_i = 1'b0;
    exp_zero(1);
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;

    // 4bpp underrun and recovery
    mode_i = MODE_4BPP;
    feed.push_back(16'hC3C3);
    set_feed();
    step();
    enable_i = 1'b1;
    exp_load(16'hC3C3);
    exp_shift(MODE_4BPP, 3);
    exp_und();
    exp_zero(1);
    steps(6);
    feed.push_back(16'h5A5A);
    set_feed();
    exp_zero(1);
    exp_load(16'h5A5A);
    exp_shift(MODE_4BPP, 3);
    exp_und();
    steps(6);
    enable_i = 1'b0;
    exp_zero(1);
    step();

    // Mode change mid-word takes effect at the next load
    mode_i = MODE_1BPP;
    feed.push_back(16'h8001);
    feed.push_back(16'h7E7E);
    set_feed();
    steps(2);
    enable_i = 1'b1;
    exp_load(16'h8001);
    step();
    mode_i = MODE_8BPP;
    exp_shift(MODE_1BPP, 15);
    exp_load(16'h7E7E);
    exp_shift(MODE_8BPP, 1);
    exp_und();
    steps(18);
    enable_i = 1'b0;
    exp_zero(1);
    step();

    // Enable drop mid-word, flush with concurrent push, restart starved
    mode_i = MODE_2BPP;
    feed.push_back(16'h1111);
    feed.push_back(16'h2222);
    set_feed();
    steps(2);
    enable_i = 1'b1;
    exp_load(16'h1111);
    exp_shift(MODE_2BPP, 3);
    steps(4);
    enable_i = 1'b0;
    exp_zero(2);
    steps(2);
    feed.push_back(16'h3333);
    set_feed();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("wready after flush", 32'(wready_o), 32'd1);
    enable_i = 1'b1;
    exp_zero(3);
    steps(3);
    feed.push_back(16'h4444);
    set_feed();
    exp_zero(1);
    exp_load(16'h4444);
    exp_shift(MODE_2BPP, 7);
    exp_und();
    steps(10);
    enable_i = 1'b0;
    exp_zero(1);
    step();

    // Reset in the middle of a word
    mode_i = MODE_1BPP;
    feed.push_back(16'hF0F0);
    feed.push_back(16'h0001);
    set_feed();
    steps(2);
    enable_i = 1'b1;
    exp_load(16'hF0F0);
    exp_shift(MODE_1BPP, 3);
    steps(4);
    reset_i = 1'b1;
    #1;
    chk_reset_outputs("async reset");
    step();
    chk_reset_outputs("reset held");
    reset_i  = 1'b0;
    enable_i = 1'b0;
    m_dat    = 16'h0000;
    #1;
    chk("wready after release", 32'(wready_o), 32'd1);
    enable_i = 1'b1;
    exp_zero(3);
    steps(3);
    feed.push_back(16'h0F0F);
    set_feed();
    exp_zero(1);
    exp_load(16'h0F0F);
    steps(2);
    enable_i = 1'b0;
    exp_zero(1);
    step();

    chk("expectation queue drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_sequencer.md
# pixel_sequencer

Drives the CGIA's configurable pixel shift register from the display-fetch side. Accepts 16-bit display words from the fetch engine over a valid/ready handshake and buffers them in a small FIFO. Issues `load` and one-hot `shift` strobes so each word is emitted as 16, 8, 4 or 2 pixels at 1, 2, 4 or 8 bpp. Sits between the video fetch unit and `shift_register`, one dot clock domain.

## Interface
Parameters:
- `BUF_DEPTH`, 2: word FIFO depth (power of two, ≥2).

Ports:
- `dotclk_i` in 1: dot clock, all logic rising-edge.
- `reset_i` in 1: asynchronous, active-high reset.
- `enable_i` in 1: 1 during active display; 0 in blanking.
- `flush_i` in 1: synchronous FIFO clear (end of line).
- `mode_i` in 2: 00=1bpp, 01=2bpp, 10=4bpp, 11=8bpp.
- `wdat_i` in 16: display word from fetch unit.
- `wvalid_i` in 1: `wdat_i` valid.
- `wready_o` out 1: FIFO can accept a word.
- `dat_o` out 16: word to shift register `dat_i`.
- `load_o` out 1: to shift register `load_i`.
- `shift1_o`/`shift2_o`/`shift4_o`/`shift8_o` out 1 each: to shift register shift strobes.
- `underrun_o` out 1: one-cycle pulse, FIFO empty when a word was due.

## Operation
- Pixels per word (PPW): 16/8/4/2 for mode 00/01/10/11. `mode_i` is sampled only at a load; mid-word changes take effect at the next load.
- FIFO: push on `wvalid_i & wready_o`; `wready_o = ~full & ~reset_i`. Pop only on a load. No bypass: a word pushed at edge k can be loaded no earlier than edge k+1. Push and pop in the same cycle are both honoured. `flush_i` empties the FIFO and wins over a same-cycle push.
- State machine, all outputs registered:
  - IDLE: strobes 0. On `enable_i` & FIFO non-empty, load and go to RUN. On `enable_i` & empty, go to STARVE with no underrun pulse.
  - RUN, cnt≠0: assert the shift strobe for the latched mode and decrement cnt.
  - RUN, cnt=0:
    - `enable_i` & non-empty: load.
    - `enable_i` & empty: pulse `underrun_o`, strobes 0, go to STARVE.
    - `~enable_i`: go to IDLE.
  - STARVE: strobes 0. On non-empty, load and go to RUN. On `~enable_i`, go to IDLE.
  - A load sets `load_o`=1 and `dat_o` to the FIFO head, pops the FIFO, latches mode, and sets cnt=PPW−1.
  - `enable_i`=0 in any state: the next cycle is IDLE with all strobes 0. FIFO contents are kept unless flushed.
- Strobes: at most one of `load_o`/`shift*_o` is high in any cycle. `dat_o` holds its last loaded value when `load_o`=0.

## Timing
- Reset values: all strobes 0, `underrun_o`=0, `dat_o`=0, state IDLE, FIFO empty, cnt=0. Reset mid-word aborts immediately.
- Steady state: one `load_o` cycle every PPW cycles, followed by PPW−1 shift cycles. 8bpp gives an alternating load/shift8 pattern.
- Startup latency: `enable_i` seen high at edge k with a non-empty FIFO gives `load_o`=1 for the cycle after edge k.
- Underrun: `underrun_o` fires in the cycle the missing load would have occurred. Recovery load happens one cycle after the FIFO becomes non-empty.
- Simultaneous events: flush + load in the same cycle loads the old head, then empties the FIFO.

## Structure
- Package `cgia_pkg`:
  - mode encoding constants `MODE_1BPP`…`MODE_8BPP`.
  - state enum `IDLE/RUN/STARVE`.
  - function `ppw(mode)`.
- Sub-module `word_fifo`: 16-bit, `BUF_DEPTH` entries, push/pop/flush, full/empty flags. The sequencer FSM and counter live in the top module.

## Test plan
- 1bpp: push 0x1234, 0xABCD, raise enable. Expect load with `dat_o`=0x1234, 15×`shift1_o`, then load 0xABCD. With the real `shift_register` attached, the MSB stream is 0001001000110100.
- 8bpp, FIFO kept full: expect load/shift8 alternation with words in push order. `wready_o` drops only when 2 words are queued.
- Underrun: 4bpp, one word queued. Expect load, 3×`shift4_o`, a single `underrun_o` pulse with strobes 0. Push 0x5A5A two cycles later: the load of 0x5A5A follows one cycle after the push.
- Mode change mid-word: 1bpp word in progress, switch `mode_i` to 11. Expect 15×`shift1_o` to finish, then load with `shift8_o` cadence.
- Flush/enable drop: drop `enable_i` mid-word, then flush with a concurrent push. Expect strobes 0 next cycle and FIFO empty. Re-enabling gives STARVE with no `underrun_o`.
- Reset asserted mid-RUN: expect all outputs 0 asynchronously and `wready_o`=0 while reset is held. After release, `wready_o`=1 and FIFO empty.
